// File: rtl/axil_pkg.sv
// Shared AXI4-lite definitions for the peripheral-side bridge.
package axil_pkg;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;

    localparam logic [AXIL_DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        WCOLL,
        BUS,
        BRESP,
        RRESP
    } axil_state_e;

endpackage

// File: rtl/axil_slave_mem_bridge.sv
// AXI4-lite slave to single-outstanding native memory request bridge, with
// read/write arbitration, a bus timeout and a saturating timeout counter.
module axil_slave_mem_bridge
    import axil_pkg::*;
#(
    parameter int unsigned              TIMEOUT   = 255,
    parameter logic [AXIL_DATA_W-1:0]   ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetn,

    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [AXIL_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,

    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [AXIL_DATA_W-1:0]   s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,

    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,

    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [AXIL_ADDR_W-1:0]   s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,

    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [AXIL_DATA_W-1:0]   s_axi_rdata,

    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AXIL_ADDR_W-1:0]   mem_addr,
    output logic [AXIL_DATA_W-1:0]   mem_wdata,
    output logic [3:0]               mem_wstrb,
    output logic                     mem_instr,
    input  logic [AXIL_DATA_W-1:0]   mem_rdata,

    output logic [15:0]              err_cnt
);

    axil_state_e state_q, state_d;

    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic                   is_wr_q, is_wr_d;
    logic                   prio_wr_q, prio_wr_d;
    logic [31:0]            tmo_q, tmo_d;
    logic [15:0]            err_cnt_q, err_cnt_d;

    logic                   mem_valid_q, mem_valid_d;
    logic [AXIL_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [AXIL_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic                   mem_instr_q, mem_instr_d;
    logic                   bvalid_q, bvalid_d;
    logic                   rvalid_q, rvalid_d;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;

    logic wr_req;
    logic aw_hs, w_hs, ar_hs;
    logic unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot[1:0]};

    assign wr_req = s_axi_awvalid | s_axi_wvalid;
    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;

    // Readies are gated by resetn so they read 0 while reset is asserted.
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        s_axi_awready = !(s_axi_arvalid && !prio_wr_q);
                        s_axi_wready  = !(s_axi_arvalid && !prio_wr_q);
                    end
                    s_axi_arready = s_axi_arvalid && !(wr_req && prio_wr_q);
                end
                WCOLL: begin
                    s_axi_awready = !aw_held_q;
                    s_axi_wready  = !w_held_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        is_wr_d     = is_wr_q;
        prio_wr_d   = prio_wr_q;
        tmo_d       = tmo_q;
        err_cnt_d   = err_cnt_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_instr_d = mem_instr_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE, WCOLL: begin
                // Write channels land straight in the request registers;
                // mem_valid stays low until both halves are present.
                if (aw_hs) begin
                    aw_held_d  = 1'b1;
                    mem_addr_d = s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held_d    = 1'b1;
                    mem_wdata_d = s_axi_wdata;
                    mem_wstrb_d = s_axi_wstrb;
                end
                if ((aw_hs || aw_held_q) && (w_hs || w_held_q)) begin
                    state_d     = BUS;
                    mem_valid_d = 1'b1;
                    mem_instr_d = 1'b0;
                    is_wr_d     = 1'b1;
                    tmo_d       = '0;
                    aw_held_d   = 1'b0;
                    w_held_d    = 1'b0;
                end else if (aw_hs || w_hs) begin
                    state_d = WCOLL;
                end else if (ar_hs) begin
                    state_d     = BUS;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = s_axi_araddr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'h0;
                    mem_instr_d = s_axi_arprot[2];
                    is_wr_d     = 1'b0;
                    tmo_d       = '0;
                end
            end
            BUS: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        state_d  = BRESP;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = mem_rdata;
                        state_d  = RRESP;
                    end
                end else if (TIMEOUT != 0 && tmo_q == TIMEOUT) begin
                    mem_valid_d = 1'b0;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        state_d  = BRESP;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = ERR_RDATA;
                        state_d  = RRESP;
                    end
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            BRESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    prio_wr_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RRESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    prio_wr_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            is_wr_q     <= 1'b0;
            prio_wr_q   <= 1'b1;
            tmo_q       <= '0;
            err_cnt_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_instr_q <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            is_wr_q     <= is_wr_d;
            prio_wr_q   <= prio_wr_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_instr_q <= mem_instr_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_instr    = mem_instr_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_axil_slave_mem_bridge.sv
// Scoreboard bench for axil_slave_mem_bridge: directed AXI4-lite traffic against
// a small latency-programmable memory model.
module tb_axil_slave_mem_bridge;
    import axil_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        mem_valid, mem_ready, mem_instr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    axil_slave_mem_bridge #(
        .TIMEOUT   (TMO),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_instr     (mem_instr),
        .mem_rdata     (mem_rdata),
        .err_cnt       (err_cnt)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        instr;
    } mem_req_t;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } resp_t;

    mem_req_t exp_mem[$];
    resp_t    exp_resp[$];
    mem_req_t mon_em;
    resp_t    mon_er;

    int n_chk  = 0;
    int n_fail = 0;

    int          mem_lat    = 1;
    bit          mem_hang   = 1'b0;
    logic [31:0] mem_rd_val = '0;
    int          vcnt       = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            done = (exp_mem.size() == 0) && (exp_resp.size() == 0) && !bvalid && !rvalid
                   && !mem_valid;
            if (done) break;
        end
        chk1("wait_done", done, 1'b1);
    endtask

    task automatic tmo_read(input logic [31:0] addr);
        mem_hang = 1'b1;
        arvalid  = 1'b1;
        araddr   = addr;
        arprot   = 3'b000;
        exp_resp.push_back(resp_t'{1'b1, 32'hDEAD_BEEF});
        cyc();
        arvalid = 1'b0;
        wait_done();
        mem_hang = 1'b0;
    endtask

    // Memory model: mem_ready on the mem_lat-th cycle of mem_valid, unless hung.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                vcnt++;
                mem_ready = !mem_hang && (vcnt == mem_lat);
                mem_rdata = mem_rd_val;
            end else begin
                vcnt      = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: compare every completed handshake against the scoreboard.
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_valid && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got addr 0x%08h, expected no request", mem_addr);
                end else begin
                    mon_em = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, mon_em.addr);
                    chk("mem_wdata", mem_wdata, mon_em.data);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(mon_em.strb));
                    chk1("mem_instr", mem_instr, mon_em.instr);
                end
            end
            if ((bvalid && bready) || (rvalid && rready)) begin
                if (exp_resp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got b=%b r=%b, expected none", bvalid, rvalid);
                end else begin
                    mon_er = exp_resp.pop_front();
                    chk1("resp_is_read", rvalid, mon_er.is_rd);
                    if (rvalid) chk("rdata", rdata, mon_er.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        resetn  = 1'b0;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        awaddr  = '0;
        wdata   = '0;
        wstrb   = '0;
        araddr  = '0;
        awprot  = '0;
        arprot  = '0;
        bready  = 1'b1;
        rready  = 1'b1;

        // Reset state, with every valid asserted to prove readies are held low.
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_awready", awready, 1'b0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_arready", arready, 1'b0);
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        resetn  = 1'b1;
        cyc();

        // Zero-wait write, AW and W together.
        mem_lat = 1;
        awvalid = 1'b1;
        awaddr  = 32'h100;
        wvalid  = 1'b1;
        wdata   = 32'hA5A5_0001;
        wstrb   = 4'hF;
        exp_mem.push_back(mem_req_t'{32'h100, 32'hA5A5_0001, 4'hF, 1'b0});
        exp_resp.push_back(resp_t'{1'b0, 32'h0});
        @(negedge clk);
        chk1("t1_awready", awready, 1'b1);
        chk1("t1_wready", wready, 1'b1);
        chk1("t1_mv_c0", mem_valid, 1'b0);
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk1("t1_mv_c1", mem_valid, 1'b1);
        chk("t1_wstrb", 32'(mem_wstrb), 32'hF);
        cyc();
        chk1("t1_mv_c2", mem_valid, 1'b0);
        chk1("t1_bvalid_c2", bvalid, 1'b1);
        wait_done();

        // W first, AW three cycles later; a read arriving meanwhile is held off.
        mem_lat = 2;
        wvalid  = 1'b1;
        wdata   = 32'h0BAD_F00D;
        wstrb   = 4'h3;
        exp_mem.push_back(mem_req_t'{32'h200, 32'h0BAD_F00D, 4'h3, 1'b0});
        exp_resp.push_back(resp_t'{1'b0, 32'h0});
        @(negedge clk);
        chk1("t2_wready_c0", wready, 1'b1);
        cyc();
        wvalid  = 1'b0;
        arvalid = 1'b1;
        araddr  = 32'h999;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                awvalid = 1'b1;
                awaddr  = 32'h200;
            end
            @(negedge clk);
            chk1("t2_mv_wcoll", mem_valid, 1'b0);
            chk1("t2_arready_wcoll", arready, 1'b0);
            chk1("t2_wready_held", wready, 1'b0);
            chk1("t2_awready_wcoll", awready, 1'b1);
            cyc();
        end
        awvalid = 1'b0;
        arvalid = 1'b0;
        chk1("t2_mv_c4", mem_valid, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h200);
        wait_done();

        // Reset while in BUS: outputs drop at once and no response follows.
        mem_hang = 1'b1;
        awvalid  = 1'b1;
        wvalid   = 1'b1;
        awaddr   = 32'h500;
        wdata    = 32'h5555_5555;
        wstrb    = 4'hF;
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk1("t6_mv_before_rst", mem_valid, 1'b1);
        cyc();
        #2 resetn = 1'b0;
        #1;
        chk1("t6_rst_mem_valid", mem_valid, 1'b0);
        chk("t6_rst_mem_addr", mem_addr, 32'h0);
        chk("t6_rst_mem_wdata", mem_wdata, 32'h0);
        chk("t6_rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk1("t6_rst_bvalid", bvalid, 1'b0);
        cyc();
        cyc();
        resetn   = 1'b1;
        mem_hang = 1'b0;
        mem_lat  = 1;
        cyc();
        chk1("t6_no_bvalid", bvalid, 1'b0);

        // Collision from reset: write wins, then a second collision goes to the read.
        awvalid    = 1'b1;
        wvalid     = 1'b1;
        awaddr     = 32'h300;
        wdata      = 32'h3333_0000;
        wstrb      = 4'hF;
        arvalid    = 1'b1;
        araddr     = 32'h304;
        arprot     = 3'b000;
        mem_rd_val = 32'hCAFE_0304;
        exp_mem.push_back(mem_req_t'{32'h300, 32'h3333_0000, 4'hF, 1'b0});
        exp_mem.push_back(mem_req_t'{32'h304, 32'h0, 4'h0, 1'b0});
        exp_mem.push_back(mem_req_t'{32'h310, 32'h3131_3131, 4'h1, 1'b0});
        exp_resp.push_back(resp_t'{1'b0, 32'h0});
        exp_resp.push_back(resp_t'{1'b1, 32'hCAFE_0304});
        exp_resp.push_back(resp_t'{1'b0, 32'h0});
        @(negedge clk);
        chk1("t3_awready", awready, 1'b1);
        chk1("t3_arready", arready, 1'b0);
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) break;
        end
        chk1("t3_bvalid_seen", bvalid, 1'b1);
        cyc();
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = 32'h310;
        wdata   = 32'h3131_3131;
        wstrb   = 4'h1;
        @(negedge clk);
        chk1("t3b_arready", arready, 1'b1);
        chk1("t3b_awready", awready, 1'b0);
        chk1("t3b_wready", wready, 1'b0);
        cyc();
        arvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) break;
        end
        chk1("t3b_aw_accept", awready && wready, 1'b1);
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_done();

        // Instruction read, memory ready on the 5th mem_valid cycle, rready held low.
        mem_lat    = 5;
        mem_rd_val = 32'h1234_5678;
        rready     = 1'b0;
        arvalid    = 1'b1;
        araddr     = 32'h40;
        arprot     = 3'b100;
        exp_mem.push_back(mem_req_t'{32'h40, 32'h0, 4'h0, 1'b1});
        exp_resp.push_back(resp_t'{1'b1, 32'h1234_5678});
        @(negedge clk);
        chk1("t4_arready", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
        chk1("t4_mem_valid", mem_valid, 1'b1);
        chk1("t4_mem_instr", mem_instr, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        for (int k = 0; k < 3; k++) begin
            chk1("t4_rvalid_held", rvalid, 1'b1);
            chk("t4_rdata_held", rdata, 32'h1234_5678);
            if (k < 2) @(negedge clk);
        end
        cyc();
        rready = 1'b1;
        wait_done();
        chk("t4_err_cnt", 32'(err_cnt), 32'h0);

        // Timed-out read: mem_valid high TMO+1 cycles, ERR_RDATA returned.
        mem_hang = 1'b1;
        arvalid  = 1'b1;
        araddr   = 32'h80;
        arprot   = 3'b000;
        exp_resp.push_back(resp_t'{1'b1, 32'hDEAD_BEEF});
        cyc();
        arvalid = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_valid) break;
            hi++;
            cyc();
        end
        chk("t5_mv_cycles", 32'(hi), TMO + 1);
        wait_done();
        chk("t5_err_cnt_1", 32'(err_cnt), 32'h1);

        // Timed-out write still answered on B.
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = 32'h90;
        wdata   = 32'h9090_9090;
        wstrb   = 4'hF;
        exp_resp.push_back(resp_t'{1'b0, 32'h0});
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_done();
        chk("t5_err_cnt_2", 32'(err_cnt), 32'h2);
        mem_hang = 1'b0;

        // Saturation of the error counter.
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        tmo_read(32'hA0);
        chk("t5_err_sat_1", 32'(err_cnt), 32'hFFFF);
        tmo_read(32'hA4);
        chk("t5_err_sat_2", 32'(err_cnt), 32'hFFFF);

        chk("end_mem_queue", 32'(exp_mem.size()), 32'h0);
        chk("end_resp_queue", 32'(exp_resp.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
